mem_loader: RTL

Hardware program loader for the multi-cycle CPU: accepts a framed byte stream over a valid/ready handshake, assembles 32-bit big-endian words, and writes them into the CPU's word-addressed unified memory at the `.text` base (word 0) or `.data` base (word 2048). It holds the CPU in reset while loading and releases it on a run command. It is the in-system counterpart of the bench's memory-image preload, and sits between a host byte source (UART receiver or bench driver) and the memory write port ahead of the CPU.

---
 rtl/mem_loader_if.sv | 22 ++
 rtl/mem_loader.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mem_loader_if.sv
// Byte-stream and memory write-port bundle for mem_loader.
// The host side drives bytes in; the loader drives the write port out.
interface mem_loader_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_loader.sv
// Framed byte-stream program loader for the multi-cycle CPU.
// Assembles big-endian words, writes .text/.data, holds the CPU meanwhile.
module mem_loader #(
    parameter int ADDR_W    = 12,
    parameter int DATA_BASE = 2048
) (
    input  logic clk,
    input  logic reset,
    mem_loader_if.slave bus,
    output logic cpu_hold,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_SEG,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_CSUM
    } state_t;

    localparam logic [7:0] SYNC_B = 8'hA5;
    localparam logic [7:0] RUN_B  = 8'hFF;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        len_hi_q;
    logic [15:0]       cnt_q;
    logic [15:0]       word_idx_q;
    logic [15:0]       word_nxt;
    logic [1:0]        byte_idx_q;
    logic [7:0]        csum_q;
    logic [31:0]       word_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              ready;
    logic              fire;
    logic [7:0]        b;
    logic              seg_load;

    assign b         = bus.in_data;
    assign fire      = bus.in_valid && ready;
    assign word_nxt  = word_idx_q + 16'd1;
    assign seg_load  = (b == 8'h00) || (b == 8'h01);

    assign bus.in_ready  = ready;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_SYNC;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b1;
        unique case (state_q)
            S_SYNC: begin
                if (fire && b == SYNC_B) state_d = S_SEG;
            end
            S_SEG: begin
                if (fire) state_d = seg_load ? S_LEN_HI : S_SYNC;
            end
            S_LEN_HI: begin
                if (fire) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (fire) begin
                    if ({len_hi_q, b} == 16'd0) state_d = S_CSUM;
                    else                        state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (fire && byte_idx_q == 2'd3) state_d = S_WRITE;
            end
            S_WRITE: begin
                ready   = 1'b0;
                state_d = (word_nxt == cnt_q) ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                if (fire) state_d = S_SYNC;
            end
            default: state_d = S_SYNC;
        endcase
    end

    // Write strobe is one cycle wide: cleared by default every edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q      <= '0;
            len_hi_q    <= '0;
            cnt_q       <= '0;
            word_idx_q  <= '0;
            byte_idx_q  <= '0;
            csum_q      <= '0;
            word_q      <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold    <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done     <= 1'b0;
            unique case (state_q)
                S_SYNC: begin
                    if (fire && b == SYNC_B) err <= 1'b0;
                end
                S_SEG: begin
                    if (fire) begin
                        if (b == RUN_B) begin
                            cpu_hold <= 1'b0;
                        end else if (seg_load) begin
                            base_q   <= b[0] ? ADDR_W'(DATA_BASE)
                                             : '0;
                            cpu_hold <= 1'b1;
                            csum_q   <= b;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_LEN_HI: begin
                    if (fire) begin
                        len_hi_q <= b;
                        csum_q   <= csum_q ^ b;
                    end
                end
                S_LEN_LO: begin
                    if (fire) begin
                        cnt_q      <= {len_hi_q, b};
                        csum_q     <= csum_q ^ b;
                        byte_idx_q <= '0;
                        word_idx_q <= '0;
                    end
                end
                S_DATA: begin
                    if (fire) begin
                        word_q     <= {word_q[23:0], b};
                        csum_q     <= csum_q ^ b;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= base_q
                                + word_idx_q[ADDR_W-1:0];
                            mem_wdata_q <= {word_q[23:0], b};
                        end
                    end
                end
                S_WRITE: begin
                    word_idx_q <= word_nxt;
                end
                S_CSUM: begin
                    if (fire) begin
                        if (csum_q == b) done <= 1'b1;
                        else             err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
